// File: rtl/fp32_subtractor_seq_if.sv
// rtl/fp32_subtractor_seq_if.sv - handshake bundle for the multi-cycle FP32 subtractor
// Purpose: groups the operand/result handshake of fp32_subtractor_seq.
// Signals:
//   in_valid / in_ready   operand pair handshake (A minuend, B subtrahend)
//   out_valid / out_ready result handshake (O result, norm_cycles left-shift count)
// Modports: master = operand producer / result consumer, slave = subtractor.
interface fp32_subtractor_seq_if #(
    parameter int DATA_TYPE = 32,
    parameter int CNT_W     = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_TYPE-1:0] A;
    logic [DATA_TYPE-1:0] B;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_TYPE-1:0] O;
    logic [CNT_W-1:0]     norm_cycles;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, O, norm_cycles
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, O, norm_cycles
    );
endinterface

// File: rtl/fp32_subtractor_seq.sv
// rtl/fp32_subtractor_seq.sv - multi-cycle truncating FP32 subtractor O = A - B
// Purpose: computes A - B as A + (-B) with one-cycle alignment, one-cycle
//   add/sub and an iterative normaliser (one shift per cycle).
// Ports:
//   CLK    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of fp32_subtractor_seq_if (in_valid/in_ready/A/B,
//          out_valid/out_ready/O/norm_cycles)
module fp32_subtractor_seq #(
    parameter int DATA_TYPE = 32,
    parameter int CNT_W     = 5
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    fp32_subtractor_seq_if.slave        bus
);
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_CALC, S_NORM, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [7:0]           a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [23:0]          a_man_q, a_man_d, b_man_q, b_man_d;
    logic                 res_sign_q, res_sign_d;
    logic [7:0]           res_exp_q, res_exp_d;
    logic [24:0]          m_q, m_d;
    logic [DATA_TYPE-1:0] o_q, o_d;
    logic [CNT_W-1:0]     norm_q, norm_d;

    // Subtraction is addition of the subtrahend with its sign flipped.
    logic [31:0] b_neg;
    logic        a_nan, b_nan, a_zero, b_zero, a_max, b_max;
    logic        a_big;
    logic [7:0]  exp_diff;
    logic [23:0] small_man, small_sh;

    assign b_neg  = {~bus.B[31], bus.B[30:0]};
    assign a_max  = (bus.A[30:23] == 8'hFF);
    assign b_max  = (b_neg[30:23] == 8'hFF);
    assign a_nan  = a_max && (bus.A[22:0] != 23'd0);
    assign b_nan  = b_max && (b_neg[22:0] != 23'd0);
    assign a_zero = (bus.A[30:0] == 31'd0);
    assign b_zero = (b_neg[30:0] == 31'd0);

    // Magnitude order: exponent first, mantissa breaks ties.
    assign a_big     = (a_exp_q > b_exp_q) || ((a_exp_q == b_exp_q) && (a_man_q >= b_man_q));
    assign exp_diff  = a_big ? (a_exp_q - b_exp_q) : (b_exp_q - a_exp_q);
    assign small_man = a_big ? b_man_q : a_man_q;
    assign small_sh  = (exp_diff >= 8'd24) ? 24'd0 : (small_man >> exp_diff);

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.O           = o_q;
    assign bus.norm_cycles = norm_q;

    always_comb begin
        state_d    = state_q;
        a_sign_d   = a_sign_q;
        a_exp_d    = a_exp_q;
        a_man_d    = a_man_q;
        b_sign_d   = b_sign_q;
        b_exp_d    = b_exp_q;
        b_man_d    = b_man_q;
        res_sign_d = res_sign_q;
        res_exp_d  = res_exp_q;
        m_d        = m_q;
        o_d        = o_q;
        norm_d     = norm_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_sign_d = bus.A[31];
                    a_exp_d  = (bus.A[30:23] == 8'd0) ? 8'd1 : bus.A[30:23];
                    a_man_d  = {bus.A[30:23] != 8'd0, bus.A[22:0]};
                    b_sign_d = b_neg[31];
                    b_exp_d  = (b_neg[30:23] == 8'd0) ? 8'd1 : b_neg[30:23];
                    b_man_d  = {b_neg[30:23] != 8'd0, b_neg[22:0]};
                    norm_d   = '0;
                    state_d  = S_DONE;
                    if (a_nan)       o_d = bus.A;
                    else if (b_nan)  o_d = b_neg;
                    else if (b_zero) o_d = bus.A;
                    else if (a_zero) o_d = b_neg;
                    else if (a_max)  o_d = bus.A;
                    else if (b_max)  o_d = b_neg;
                    else             state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // a_man/b_man now hold the large and aligned small mantissa;
                // the operand signs are kept to choose add or subtract.
                res_sign_d = a_big ? a_sign_q : b_sign_q;
                res_exp_d  = a_big ? a_exp_q : b_exp_q;
                a_man_d    = a_big ? a_man_q : b_man_q;
                b_man_d    = small_sh;
                state_d    = S_CALC;
            end
            S_CALC: begin
                if (a_sign_q == b_sign_q) m_d = {1'b0, a_man_q} + {1'b0, b_man_q};
                else                      m_d = {1'b0, a_man_q} - {1'b0, b_man_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                if (m_q == 25'd0) begin
                    o_d     = '0;
                    state_d = S_DONE;
                end else if (m_q[24]) begin
                    m_d       = m_q >> 1;
                    res_exp_d = res_exp_q + 8'd1;
                    if (res_exp_q == 8'd254) begin
                        o_d     = {res_sign_q, 8'hFF, 23'd0};
                        state_d = S_DONE;
                    end
                end else if (!m_q[23] && (res_exp_q > 8'd1)) begin
                    m_d       = m_q << 1;
                    res_exp_d = res_exp_q - 8'd1;
                    norm_d    = norm_q + CNT_W'(1);
                end else if (m_q[23]) begin
                    o_d     = {res_sign_q, res_exp_q, m_q[22:0]};
                    state_d = S_DONE;
                end else begin
                    // Exponent floor reached without a leading one: denormal.
                    o_d     = {res_sign_q, 8'h00, m_q[22:0]};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_sign_q   <= 1'b0;
            a_exp_q    <= 8'd0;
            a_man_q    <= 24'd0;
            b_sign_q   <= 1'b0;
            b_exp_q    <= 8'd0;
            b_man_q    <= 24'd0;
            res_sign_q <= 1'b0;
            res_exp_q  <= 8'd0;
            m_q        <= 25'd0;
            o_q        <= '0;
            norm_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_sign_q   <= a_sign_d;
            a_exp_q    <= a_exp_d;
            a_man_q    <= a_man_d;
            b_sign_q   <= b_sign_d;
            b_exp_q    <= b_exp_d;
            b_man_q    <= b_man_d;
            res_sign_q <= res_sign_d;
            res_exp_q  <= res_exp_d;
            m_q        <= m_d;
            o_q        <= o_d;
            norm_q     <= norm_d;
        end
    end
endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// tb/tb_fp32_subtractor_seq.sv - self-checking bench for fp32_subtractor_seq
module tb_fp32_subtractor_seq;
    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    fp32_subtractor_seq_if #(.DATA_TYPE(32), .CNT_W(5)) bus ();
    fp32_subtractor_seq #(.DATA_TYPE(32), .CNT_W(5)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_o;
    int exp_lat, exp_norm;
    bit mon_en = 1'b0, pending = 1'b0, holding = 1'b0;
    int cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value-level FP32 A - B with truncated alignment and a
    // leading-one search for normalisation; latency derived from step counts.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output int lat, output int nsh);
        logic [31:0] bn;
        int ea, eb, e, d, p, k;
        longint unsigned ma, mb, mbig, msm, m;
        logic s;
        bn = {~b[31], b[30:0]};
        lat = 1; nsh = 0; o = 32'd0;
        if (a[30:23] == 8'hFF && a[22:0] != 0)        o = a;
        else if (bn[30:23] == 8'hFF && bn[22:0] != 0) o = bn;
        else if (bn[30:0] == 0)                       o = a;
        else if (a[30:0] == 0)                        o = bn;
        else if (a[30:23] == 8'hFF)                   o = a;
        else if (bn[30:23] == 8'hFF)                  o = bn;
        else begin
            ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
            eb = (bn[30:23] == 0) ? 1 : int'(bn[30:23]);
            ma = longint'(a[22:0]) + ((a[30:23] != 0) ? 64'h800000 : 64'h0);
            mb = longint'(bn[22:0]) + ((bn[30:23] != 0) ? 64'h800000 : 64'h0);
            if ((ea > eb) || (ea == eb && ma >= mb)) begin
                e = ea; s = a[31]; mbig = ma; msm = mb; d = ea - eb;
            end else begin
                e = eb; s = bn[31]; mbig = mb; msm = ma; d = eb - ea;
            end
            msm = (d >= 24) ? 64'd0 : (msm >> d);
            m = (a[31] == bn[31]) ? mbig + msm : mbig - msm;
            lat = 4;
            if (m != 0) begin
                p = 0;
                for (int i = 0; i < 25; i++) if (m[i]) p = i;
                if (p == 24) begin
                    e = e + 1;
                    if (e == 255) o = {s, 8'hFF, 23'd0};
                    else begin o = {s, 8'(e), 23'(m >> 1)}; lat = 5; end
                end else begin
                    k = 23 - p;
                    if (e - k < 1) k = e - 1;
                    o = {s, (e - k == 1 && !m[p] ? 8'd0 : 8'(e - k)), 23'(m << k)};
                    if (((m << k) & 64'h800000) == 0) o[30:23] = 8'd0;
                    lat = 4 + k; nsh = k;
                end
            end
        end
    endfunction

    // Compare process: latency/result at first out_valid, stability while held.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (pending) begin
                cnt++;
                if (bus.out_valid) begin
                    chk("latency", cnt, exp_lat);
                    chk("O", bus.O, exp_o);
                    chk("norm_cycles", 32'(bus.norm_cycles), exp_norm);
                    pending = 1'b0;
                    holding = 1'b1;
                end else if (cnt > 40) begin
                    chk("result_timeout", 32'(bus.out_valid), 32'd1);
                    pending = 1'b0;
                end
            end else if (holding && bus.out_valid) begin
                chk("O_hold", bus.O, exp_o);
                chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] mo;
        int ml, mn, waitc;
        model(a, b, mo, ml, mn);
        exp_o = mo; exp_lat = ml; exp_norm = mn;
        @(posedge CLK); #1;
        bus.A = a; bus.B = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge CLK);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge CLK); #1;
        bus.in_valid = 1'b0; cnt = 0; holding = 1'b0; pending = 1'b1;
        waitc = 0;
        while (!bus.out_valid && waitc < 60) begin @(negedge CLK); waitc++; end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            rst_n = 1'b0; #2; rst_n = 1'b1;
            pending = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge CLK); #1;
            bus.in_valid = 1'($urandom_range(0, 1)); bus.A = $urandom; bus.B = $urandom;
        end
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; holding = 1'b0;
        @(negedge CLK);
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic pin(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] o_req, input int lat_req, input int n_req);
        logic [31:0] mo;
        int ml, mn;
        model(a, b, mo, ml, mn);
        chk("model_O", mo, o_req);
        chk("model_lat", ml, lat_req);
        chk("model_norm", mn, n_req);
    endtask

    initial begin
        logic [31:0] a, b, r;
        int kind;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0;

        pin(32'h40400000, 32'h3F800000, 32'h40000000, 4, 0);
        pin(32'h3F800000, 32'hBF800000, 32'h40000000, 5, 0);
        pin(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27, 23);
        pin(32'h40490FDB, 32'h40490FDB, 32'h00000000, 4, 0);
        pin(32'h00000000, 32'h3F800000, 32'hBF800000, 1, 0);
        pin(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_O", bus.O, 32'd0);
        chk("rst_norm", 32'(bus.norm_cycles), 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;

        do_op(32'h40400000, 32'h3F800000, 0);
        do_op(32'h3F800000, 32'hBF800000, 0);
        do_op(32'h3F800000, 32'h3F7FFFFF, 1);
        do_op(32'h40490FDB, 32'h40490FDB, 0);
        do_op(32'h00000000, 32'h3F800000, 0);
        do_op(32'h7FC00000, 32'h3F800000, 5);

        // Reset while normalising the long-shift case.
        mon_en = 1'b0;
        @(posedge CLK); #1;
        bus.A = 32'h3F800000; bus.B = 32'h3F7FFFFF; bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge CLK);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_O", bus.O, 32'd0);
        chk("mid_rst_norm", 32'(bus.norm_cycles), 32'd0);
        @(posedge CLK); #1 rst_n = 1'b1;
        mon_en = 1'b1;
        do_op(32'h40400000, 32'h3F800000, 0);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom; b = $urandom; r = $urandom;
            case (kind)
                0: ;
                1: b = a ^ (r & 32'h000000FF);
                2: b = a;
                3: a[30:23] = 8'd0;
                4: begin b[30:23] = 8'd0; if (r[0]) b[22:0] = 23'd0; end
                5: begin a[30:23] = 8'hFF; if (r[0]) a[22:0] = 23'd0; end
                6: begin a = {1'b0, 8'hFE, r[22:0]}; b = {1'b1, 8'hFE, b[22:0]}; end
                default: b = {r[31], a[30:23] ^ {6'd0, r[1:0]}, b[22:0]};
            endcase
            do_op(a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
